// File: rtl/bullet_scheduler_if.sv
// Signal bundle between the fire-request decode, the scheduler and the bullet slot array.
// The slave modport is the scheduler's view; the master modport drives requests and slot reports.
interface bullet_scheduler_if #(
  parameter int NSLOTS = 4
);
  logic [1:0]        fire_req;
  logic [NSLOTS-1:0] slot_done;
  logic [NSLOTS-1:0] slot_hit;
  logic [NSLOTS-1:0] launch;
  logic              launch_owner;
  logic [NSLOTS-1:0] slot_owner;
  logic [NSLOTS-1:0] slot_alloc;
  logic [1:0]        fire_ack;
  logic [1:0]        score_event;
  logic [3:0]        hits0;
  logic [3:0]        hits1;

  modport master (
    output fire_req, slot_done, slot_hit,
    input  launch, launch_owner, slot_owner, slot_alloc, fire_ack, score_event, hits0, hits1
  );

  modport slave (
    input  fire_req, slot_done, slot_hit,
    output launch, launch_owner, slot_owner, slot_alloc, fire_ack, score_event, hits0, hits1
  );
endinterface

// File: rtl/bullet_scheduler.sv
// Shares NSLOTS bullet slots between two tanks: fire edge detect, cooldown, in-flight limit,
// round-robin tie break, slot allocation and hit scoring. All outputs are registered.
module bullet_scheduler #(
  parameter int NSLOTS         = 4,
  parameter int MAX_PER_PLAYER = 2,
  parameter int COOLDOWN       = 8
) (
  input  logic              frame_clk,
  input  logic              Reset_n,
  input  logic              game_over,
  bullet_scheduler_if.slave bus
);
  localparam int         SW      = $clog2(NSLOTS);
  localparam logic [3:0] MAX_CNT = 4'(MAX_PER_PLAYER);
  localparam logic [7:0] COOL_LD = 8'(COOLDOWN);

  logic [1:0]        fire_q, fire_d;
  logic [1:0]        pending_q, pending_d;
  logic [7:0]        cool_q [2];
  logic [7:0]        cool_d [2];
  logic [3:0]        cnt_q [2];
  logic [3:0]        cnt_d [2];
  logic [3:0]        hits_q [2];
  logic [3:0]        hits_d [2];
  logic              last_grant_q, last_grant_d;
  logic [NSLOTS-1:0] alloc_q, alloc_d;
  logic [NSLOTS-1:0] owner_q, owner_d;
  logic [NSLOTS-1:0] launch_q, launch_d;
  logic              launch_owner_q, launch_owner_d;
  logic [1:0]        fire_ack_q, fire_ack_d;
  logic [1:0]        score_q, score_d;

  logic [1:0]        fire_rise_s;
  logic [1:0]        eligible_s;
  logic [1:0]        hit_any_s;
  logic              grant_s;
  logic              grant_p_s;
  logic [SW-1:0]     slot_s;
  logic [NSLOTS-1:0] retire_s;
  logic [3:0]        ret_cnt_s [2];

  // Request qualification, arbitration, free-slot search and per-player retire tallies.
  always_comb begin
    fire_rise_s = bus.fire_req & ~fire_q;
    retire_s    = bus.slot_done & alloc_q;
    for (int p = 0; p < 2; p++) begin
      eligible_s[p] = pending_q[p] && (cool_q[p] == 8'd0) && (cnt_q[p] < MAX_CNT) && !(&alloc_q);
      ret_cnt_s[p]  = 4'd0;
      hit_any_s[p]  = 1'b0;
      for (int i = 0; i < NSLOTS; i++) begin
        if (retire_s[i] && (owner_q[i] == 1'(p))) begin
          ret_cnt_s[p] = ret_cnt_s[p] + 4'd1;
          hit_any_s[p] = hit_any_s[p] | bus.slot_hit[i];
        end else begin
          ret_cnt_s[p] = ret_cnt_s[p];
        end
      end
    end
    // Descending scan so the lowest free index is the one left standing.
    slot_s = {SW{1'b0}};
    for (int i = NSLOTS - 1; i >= 0; i--) begin
      slot_s = alloc_q[i] ? slot_s : SW'(i);
    end
    case (eligible_s)
      2'b01:   begin grant_s = 1'b1; grant_p_s = 1'b0;          end
      2'b10:   begin grant_s = 1'b1; grant_p_s = 1'b1;          end
      2'b11:   begin grant_s = 1'b1; grant_p_s = ~last_grant_q; end
      default: begin grant_s = 1'b0; grant_p_s = 1'b0;          end
    endcase
  end

  // Next-state: grant bookkeeping, retire bookkeeping, and the game_over clear overriding both.
  always_comb begin
    fire_d         = bus.fire_req;
    pending_d      = pending_q | fire_rise_s;
    last_grant_d   = last_grant_q;
    alloc_d        = alloc_q & ~retire_s;
    owner_d        = owner_q;
    launch_d       = {NSLOTS{1'b0}};
    launch_owner_d = 1'b0;
    fire_ack_d     = 2'b00;
    score_d        = hit_any_s;
    for (int p = 0; p < 2; p++) begin
      cool_d[p] = (cool_q[p] != 8'd0) ? cool_q[p] - 8'd1 : 8'd0;
      cnt_d[p]  = cnt_q[p] - ret_cnt_s[p];
      hits_d[p] = (hit_any_s[p] && (hits_q[p] != 4'd15)) ? hits_q[p] + 4'd1 : hits_q[p];
    end
    if (grant_s) begin
      alloc_d[slot_s]       = 1'b1;
      owner_d[slot_s]       = grant_p_s;
      launch_d[slot_s]      = 1'b1;
      launch_owner_d        = grant_p_s;
      fire_ack_d[grant_p_s] = 1'b1;
      pending_d[grant_p_s]  = 1'b0;
      cool_d[grant_p_s]     = COOL_LD;
      cnt_d[grant_p_s]      = cnt_d[grant_p_s] + 4'd1;
      last_grant_d          = grant_p_s;
    end else begin
      last_grant_d = last_grant_q;
    end
    if (game_over) begin
      fire_d         = 2'b00;
      pending_d      = 2'b00;
      last_grant_d   = 1'b1;
      alloc_d        = {NSLOTS{1'b0}};
      owner_d        = {NSLOTS{1'b0}};
      launch_d       = {NSLOTS{1'b0}};
      launch_owner_d = 1'b0;
      fire_ack_d     = 2'b00;
      score_d        = 2'b00;
      for (int p = 0; p < 2; p++) begin
        cool_d[p] = 8'd0;
        cnt_d[p]  = 4'd0;
        hits_d[p] = 4'd0;
      end
    end else begin
      score_d = score_d;
    end
  end

  // State and output registers.
  always_ff @(posedge frame_clk or negedge Reset_n) begin
    if (!Reset_n) begin
      fire_q         <= 2'b00;
      pending_q      <= 2'b00;
      last_grant_q   <= 1'b1;
      alloc_q        <= {NSLOTS{1'b0}};
      owner_q        <= {NSLOTS{1'b0}};
      launch_q       <= {NSLOTS{1'b0}};
      launch_owner_q <= 1'b0;
      fire_ack_q     <= 2'b00;
      score_q        <= 2'b00;
      for (int p = 0; p < 2; p++) begin
        cool_q[p] <= 8'd0;
        cnt_q[p]  <= 4'd0;
        hits_q[p] <= 4'd0;
      end
    end else begin
      fire_q         <= fire_d;
      pending_q      <= pending_d;
      last_grant_q   <= last_grant_d;
      alloc_q        <= alloc_d;
      owner_q        <= owner_d;
      launch_q       <= launch_d;
      launch_owner_q <= launch_owner_d;
      fire_ack_q     <= fire_ack_d;
      score_q        <= score_d;
      for (int p = 0; p < 2; p++) begin
        cool_q[p] <= cool_d[p];
        cnt_q[p]  <= cnt_d[p];
        hits_q[p] <= hits_d[p];
      end
    end
  end

  assign bus.launch       = launch_q;
  assign bus.launch_owner = launch_owner_q;
  assign bus.slot_owner   = owner_q;
  assign bus.slot_alloc   = alloc_q;
  assign bus.fire_ack     = fire_ack_q;
  assign bus.score_event  = score_q;
  assign bus.hits0        = hits_q[0];
  assign bus.hits1        = hits_q[1];
endmodule

// File: tb/tb_bullet_scheduler.sv
// Scoreboard bench for bullet_scheduler: expected launches are queued with their due cycle
// when fire stimulus is driven, and matched against launch pulses as they appear.
module tb_bullet_scheduler;
  logic clk = 1'b0;
  logic rst_n;
  logic game_over;
  int   cyc;
  int   n_tests;
  int   n_fail;

  typedef struct {
    int         cyc;
    logic [3:0] launch;
    logic       owner;
  } exp_t;
  exp_t sb_q[$];

  bullet_scheduler_if #(.NSLOTS(4)) bus ();

  bullet_scheduler #(.NSLOTS(4), .MAX_PER_PLAYER(2), .COOLDOWN(8)) dut (
    .frame_clk (clk),
    .Reset_n   (rst_n),
    .game_over (game_over),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic push_launch(input int at, input logic [3:0] l, input logic o);
    exp_t e;
    e.cyc = at; e.launch = l; e.owner = o;
    sb_q.push_back(e);
  endtask

  task automatic monitor();
    exp_t e;
    while (sb_q.size() > 0 && sb_q[0].cyc < cyc) begin
      e = sb_q.pop_front();
      check_eq("missed_launch", 32'(e.cyc), 32'(-1));
    end
    if (bus.launch != 4'b0000) begin
      if (sb_q.size() == 0) begin
        check_eq("unexpected_launch", 32'(bus.launch), 32'd0);
      end else begin
        e = sb_q.pop_front();
        check_eq("launch_cycle", 32'(cyc), 32'(e.cyc));
        check_eq("launch_slot", 32'(bus.launch), 32'(e.launch));
        check_eq("launch_owner", 32'(bus.launch_owner), 32'(e.owner));
        check_eq("fire_ack", 32'(bus.fire_ack), e.owner ? 32'd2 : 32'd1);
      end
    end else begin
      check_eq("idle_fire_ack", 32'(bus.fire_ack), 32'd0);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    monitor();
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic fire(input logic [1:0] p);
    bus.fire_req = p;
    tick();
    bus.fire_req = 2'b00;
  endtask

  task automatic retire(input logic [3:0] done, input logic [3:0] hit);
    bus.slot_done = done;
    bus.slot_hit  = hit;
    tick();
    bus.slot_done = 4'b0000;
    bus.slot_hit  = 4'b0000;
  endtask

  task automatic clear_game();
    game_over = 1'b1;
    tick();
    game_over = 1'b0;
    check_eq("clear_alloc", 32'(bus.slot_alloc), 32'd0);
    run(2);
  endtask

  initial begin
    int c;
    n_tests = 0; n_fail = 0; cyc = 0;
    rst_n = 1'b0; game_over = 1'b0;
    bus.fire_req = 2'b00; bus.slot_done = 4'b0000; bus.slot_hit = 4'b0000;

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_launch", 32'(bus.launch), 32'd0);
    check_eq("rst_owner_l", 32'(bus.launch_owner), 32'd0);
    check_eq("rst_alloc", 32'(bus.slot_alloc), 32'd0);
    check_eq("rst_slot_owner", 32'(bus.slot_owner), 32'd0);
    check_eq("rst_ack", 32'(bus.fire_ack), 32'd0);
    check_eq("rst_score", 32'(bus.score_event), 32'd0);
    check_eq("rst_hits0", 32'(bus.hits0), 32'd0);
    check_eq("rst_hits1", 32'(bus.hits1), 32'd0);
    rst_n = 1'b1;
    run(2);

    // Single fire held for 20 cycles: exactly one launch
    c = cyc;
    push_launch(c + 2, 4'b0001, 1'b0);
    bus.fire_req = 2'b01;
    run(20);
    bus.fire_req = 2'b00;
    check_eq("single_alloc", 32'(bus.slot_alloc), 32'h1);
    check_eq("single_owner", 32'(bus.slot_owner), 32'h0);
    retire(4'b0001, 4'b0000);
    check_eq("single_retired", 32'(bus.slot_alloc), 32'h0);
    check_eq("single_no_score", 32'(bus.score_event), 32'h0);

    // Tie and round-robin
    clear_game();
    c = cyc;
    push_launch(c + 2, 4'b0001, 1'b0);
    push_launch(c + 3, 4'b0010, 1'b1);
    fire(2'b11);
    run(11);
    c = cyc;
    push_launch(c + 2, 4'b0100, 1'b0);
    push_launch(c + 3, 4'b1000, 1'b1);
    fire(2'b11);
    run(2);
    check_eq("rr_alloc", 32'(bus.slot_alloc), 32'hF);
    check_eq("rr_owner", 32'(bus.slot_owner), 32'hA);
    run(3);

    // In-flight limit, then a retire frees slot 0 for the third request
    clear_game();
    c = cyc;
    push_launch(c + 2, 4'b0001, 1'b0);
    fire(2'b01);
    run(9);
    push_launch(c + 12, 4'b0010, 1'b0);
    fire(2'b01);
    run(9);
    fire(2'b01);
    run(9);
    check_eq("limit_alloc", 32'(bus.slot_alloc), 32'h3);
    c = cyc;
    push_launch(c + 2, 4'b0001, 1'b0);
    retire(4'b0001, 4'b0000);
    check_eq("limit_freed", 32'(bus.slot_alloc), 32'h2);
    tick();
    check_eq("limit_realloc", 32'(bus.slot_alloc), 32'h3);
    run(3);

    // Cooldown: second press 3 cycles after a grant lands COOLDOWN+1 after it
    clear_game();
    c = cyc;
    push_launch(c + 2, 4'b0001, 1'b0);
    fire(2'b01);
    run(4);
    push_launch(c + 11, 4'b0010, 1'b0);
    fire(2'b01);
    run(7);

    // Hit accounting and saturation
    clear_game();
    c = cyc;
    push_launch(c + 2, 4'b0001, 1'b0);
    push_launch(c + 3, 4'b0010, 1'b1);
    fire(2'b11);
    run(2);
    retire(4'b0010, 4'b0010);
    check_eq("hit_score", 32'(bus.score_event), 32'h2);
    check_eq("hit_hits1", 32'(bus.hits1), 32'd1);
    check_eq("hit_alloc", 32'(bus.slot_alloc), 32'h1);
    tick();
    check_eq("hit_score_pulse", 32'(bus.score_event), 32'h0);
    run(8);
    for (int k = 2; k <= 16; k++) begin
      c = cyc;
      push_launch(c + 2, 4'b0010, 1'b1);
      fire(2'b10);
      tick();
      retire(4'b0010, 4'b0010);
      check_eq("sat_hits1", 32'(bus.hits1), (k > 15) ? 32'd15 : 32'(k));
      check_eq("sat_score", 32'(bus.score_event), 32'h2);
      run(8);
    end
    check_eq("sat_hits0", 32'(bus.hits0), 32'd0);

    // Spurious retire on a free slot is ignored, including its hit
    retire(4'b0010, 4'b0010);
    check_eq("spur_alloc", 32'(bus.slot_alloc), 32'h1);
    check_eq("spur_score", 32'(bus.score_event), 32'h0);
    check_eq("spur_hits1", 32'(bus.hits1), 32'd15);

    // game_over with 3 slots allocated and a request pending
    clear_game();
    check_eq("go_hits1", 32'(bus.hits1), 32'd0);
    c = cyc;
    push_launch(c + 2, 4'b0001, 1'b0);
    push_launch(c + 3, 4'b0010, 1'b1);
    fire(2'b11);
    run(10);
    push_launch(c + 13, 4'b0100, 1'b0);
    fire(2'b01);
    run(12);
    fire(2'b01);
    tick();
    check_eq("go_pre_alloc", 32'(bus.slot_alloc), 32'h7);
    game_over = 1'b1;
    tick();
    game_over = 1'b0;
    check_eq("go_alloc", 32'(bus.slot_alloc), 32'h0);
    check_eq("go_slot_owner", 32'(bus.slot_owner), 32'h0);
    check_eq("go_launch", 32'(bus.launch), 32'h0);
    run(20);

    check_eq("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/bullet_scheduler.md
# bullet_scheduler

Shares a fixed pool of bullet-engine slots between the two tanks. Each slot is one bullet datapath (position/motion/collision). The block edge-detects each player's fire request, enforces a per-player cooldown and in-flight limit, and arbitrates round-robin when both players are eligible. It issues one-cycle launch pulses to free slots, tracks slot ownership, and turns slot retire/hit reports into per-player score events. It sits between the keycode decode and the bullet slot array, clocked on the frame clock.

## Interface
- NSLOTS, 4: number of bullet slots in the pool (2..8)
- MAX_PER_PLAYER, 2: maximum in-flight bullets per player (1..NSLOTS)
- COOLDOWN, 8: frames a player must wait after a launch before the next grant (1..255)
- frame_clk  in  1  frame clock; all state changes on rising edge
- Reset_n  in  1  asynchronous, active-low reset
- game_over  in  1  synchronous clear; same effect as reset, applied at the next edge
- fire_req  in  2  level fire request per player (bit0 = tank 1, bit1 = tank 2)
- slot_done  in  NSLOTS  one-cycle pulse: slot's bullet retired (wall, block or tank)
- slot_hit  in  NSLOTS  qualifies slot_done: retirement was a tank hit
- launch  out  NSLOTS  one-hot, one-cycle pulse: start this slot
- launch_owner  out  1  player ID for the current launch; valid only while launch != 0
- slot_owner  out  NSLOTS  owning player per slot; valid while that slot is allocated
- slot_alloc  out  NSLOTS  slot is allocated (in flight)
- fire_ack  out  2  one-cycle pulse per player on grant
- score_event  out  2  one-cycle pulse per player when that player's bullet hits a tank
- hits0, hits1  out  4  saturating hit counters per player

## Operation
- Edge detect: fire_rise[p] = fire_req[p] & ~fire_q[p]. fire_q is registered every cycle. Holding fire_req high gives exactly one request.
- pending[p] is set on fire_rise[p]. It stays set until granted or cleared by reset/game_over. A second rise while pending is absorbed, with no queueing.
- eligible[p] = pending[p] & (cool[p]==0) & (cnt[p] < MAX_PER_PLAYER) & (slot_alloc != all-ones).
- Arbitration picks at most one grant per cycle.
  - If only one player is eligible, that player is granted.
  - If both are eligible, the player != last_grant is granted. last_grant resets to 1, so tank 1 wins the first tie.
- Slot choice: the lowest-index slot with slot_alloc == 0.
- On grant (registered at the edge):
  - launch[slot] = 1 and launch_owner = p.
  - slot_alloc[slot] set; slot_owner[slot] = p.
  - cnt[p] incremented; cool[p] = COOLDOWN; pending[p] cleared.
  - fire_ack[p] = 1; last_grant = p.
- Cooldown: cool[p] decrements by 1 per cycle while nonzero, and is loaded on grant.
- Retire: slot_done[i] with slot_alloc[i] = 1 clears slot_alloc[i] and decrements cnt[slot_owner[i]].
  - If slot_hit[i] is also set, score_event[owner] pulses and hits[owner] increments, saturating at 15.
  - slot_done on an unallocated slot is ignored, including its slot_hit.
- Several slots may retire in the same cycle.
  - cnt decrements by the number of that player's retirements.
  - score_event is the OR of that player's hits.
  - hits increments by 1 only.
- Simultaneous retire and grant:
  - A retiring slot is not free in that cycle; it becomes grantable the next cycle.
  - cnt[p] nets both changes.
- Registers: fire_q, pending, cool[2], cnt[2], last_grant, slot_alloc, slot_owner, hits, and the pulse outputs.
- State summary per player: IDLE (no pending), WAIT (pending, not eligible), then GRANT for one cycle, which returns to IDLE.

## Timing
- Reset (Reset_n low, async):
  - All outputs 0: launch, launch_owner, slot_alloc, slot_owner, fire_ack, score_event, hits0, hits1.
  - Internally: fire_q = 0, pending = 0, cool = 0, cnt = 0, last_grant = 1.
- game_over high at edge k: the same values are loaded at edge k. This overrides any grant or retire at edge k.
- Fire latency: fire_req rises before edge k. pending is set at edge k. launch and fire_ack are high between edge k+1 and edge k+2, if eligible at k+1.
- Minimum spacing between two grants to the same player is COOLDOWN+1 cycles.
- A retire at edge k frees the slot for a grant decided at edge k+1.
- All outputs are registered; there are no combinational input-to-output paths.
- Reset mid-flight drops all allocations. Slots must also be reset by the same Reset_n.

## Test plan
- Single fire: Reset_n released; fire_req = 01 held for 20 cycles.
  - Expect exactly one launch = 0001, owner 0, fire_ack = 01, two edges after the rise.
  - slot_alloc = 0001 after that.
- Tie and round-robin: both players pending in the same cycle.
  - First grant: tank 1 gets slot 0.
  - Next eligible cycle: tank 2 gets slot 1.
  - Repeat after cooldown: tank 1 gets slot 2 and tank 2 gets slot 3 (alternation continues).
- Limits:
  - Tank 1 fires 3 times, spaced by 10 cycles, with no retirements. Expect 2 launches; the third stays pending.
  - slot_done[0] pulse: the third launch occurs two cycles later, into slot 0.
- Cooldown: tank 1 presses again 3 cycles after a grant. Expect the grant exactly COOLDOWN+1 = 9 cycles after the first.
- Hit accounting: slot 1 owned by tank 2 gets slot_done = slot_hit = 0010. Expect:
  - score_event = 10 for one cycle.
  - hits1 = 1.
  - slot_alloc bit 1 cleared.
  - A 16th hit leaves hits1 = 15.
- Clear and spurious input:
  - slot_done on a free slot: no change.
  - game_over during a pending request with 3 slots allocated: all state zero next edge, and no launch follows.
